// File: rtl/rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_if
// Purpose : bundles the register-file write-side signals of rf_wb_arbiter.
// Signals : pipe_*      in-order pipeline writeback (valid, rd, data)
//           ll_*        long-latency result handshake (valid/ready, rd, data)
//           rs1/rs2     hazard query indices, rs*_pending answers
//           rf_*        registered register-file write port
//           fifo_count  occupied long-latency queue entries (incl. killed)
// Modports: slave  - the arbiter itself
//           master - the surrounding core / stimulus
// ---------------------------------------------------------------------------
interface rf_wb_arbiter_if #(
    parameter int DEPTH  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
);
    logic                     pipe_wen;
    logic [REG_W-1:0]         pipe_rd;
    logic [DATA_W-1:0]        pipe_wdata;
    logic                     ll_valid;
    logic                     ll_ready;
    logic [REG_W-1:0]         ll_rd;
    logic [DATA_W-1:0]        ll_wdata;
    logic [REG_W-1:0]         rs1;
    logic [REG_W-1:0]         rs2;
    logic                     rs1_pending;
    logic                     rs2_pending;
    logic                     rf_wen;
    logic [REG_W-1:0]         rf_rd;
    logic [DATA_W-1:0]        rf_wdata;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  pipe_wen, pipe_rd, pipe_wdata, ll_valid, ll_rd, ll_wdata, rs1, rs2,
        output ll_ready, rs1_pending, rs2_pending, rf_wen, rf_rd, rf_wdata, fifo_count
    );

    modport master (
        output pipe_wen, pipe_rd, pipe_wdata, ll_valid, ll_rd, ll_wdata, rs1, rs2,
        input  ll_ready, rs1_pending, rs2_pending, rf_wen, rf_rd, rf_wdata, fifo_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Purpose : merges pipeline writeback and queued long-latency results into the
//           single register-file write port. The pipeline always wins; queued
//           results drain when the port is free. A pipeline write kills older
//           queued writes to the same register. Pending-write status for rs1/rs2
//           is exported for the hazard unit.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - rf_wb_arbiter_if.slave (see interface file)
// Options : RF_WB_BYPASS_EN - when defined, a long-latency result arriving
//           while the queue is empty and the pipeline slot is free goes
//           straight to the output register (1-cycle latency).
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  live_q, live_d;
    logic [REG_W-1:0]  rd_q    [DEPTH];
    logic [REG_W-1:0]  rd_d    [DEPTH];
    logic [DATA_W-1:0] wdata_q [DEPTH];
    logic [DATA_W-1:0] wdata_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rf_wen_q, rf_wen_d;
    logic [REG_W-1:0]  rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic [DEPTH-1:0]  kill_vec, rs1_hit, rs2_hit;
    logic              pipe_take, fifo_empty, pop, push, push_killed, bypass;

    // Per-entry comparators: WAW kill and hazard lookups.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign kill_vec[gi] = pipe_take && (rd_q[gi] == bus.pipe_rd);
        assign rs1_hit[gi]  = live_q[gi] && (rd_q[gi] == bus.rs1);
        assign rs2_hit[gi]  = live_q[gi] && (rd_q[gi] == bus.rs2);
    end

    assign pipe_take  = bus.pipe_wen && (bus.pipe_rd != '0);
    assign fifo_empty = (count_q == '0);
    assign bus.ll_ready = (count_q < CW'(DEPTH));

`ifdef RF_WB_BYPASS_EN
    assign bypass = fifo_empty && !pipe_take && bus.ll_valid && (bus.ll_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // A dead head is discarded even while the pipeline owns the port; a live
    // head only leaves when it is actually written.
    assign pop  = !fifo_empty && (!live_q[head_q] || !pipe_take);
    // Writes to x0 complete the handshake but are never stored.
    assign push = bus.ll_valid && bus.ll_ready && (bus.ll_rd != '0) && !bypass;
    // The same-cycle pipeline write is younger than the arriving result.
    assign push_killed = pipe_take && (bus.ll_rd == bus.pipe_rd);

    always_comb begin
        live_d     = live_q & ~kill_vec;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        head_d     = head_q;
        tail_d     = tail_q;
        rf_wen_d   = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;

        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PW'(1);
        end
        // Tail never equals head here when pop is also set: push needs
        // count < DEPTH, pop needs count > 0.
        if (push) begin
            live_d[tail_q]  = !push_killed;
            rd_d[tail_q]    = bus.ll_rd;
            wdata_d[tail_q] = bus.ll_wdata;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (pipe_take) begin
            rf_wen_d   = 1'b1;
            rf_rd_d    = bus.pipe_rd;
            rf_wdata_d = bus.pipe_wdata;
        end else if (!fifo_empty && live_q[head_q]) begin
            rf_wen_d   = 1'b1;
            rf_rd_d    = rd_q[head_q];
            rf_wdata_d = wdata_q[head_q];
        end else if (bypass) begin
            rf_wen_d   = 1'b1;
            rf_rd_d    = bus.ll_rd;
            rf_wdata_d = bus.ll_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]    <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            live_q     <= live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_wen_q   <= rf_wen_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]    <= rd_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

    assign bus.rf_wen     = rf_wen_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.fifo_count = count_q;

    assign bus.rs1_pending = (bus.rs1 != '0) &&
                             ((|rs1_hit) || (rf_wen_q && (rf_rd_q == bus.rs1)));
    assign bus.rs2_pending = (bus.rs2 != '0) &&
                             ((|rs2_hit) || (rf_wen_q && (rf_rd_q == bus.rs2)));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Purpose : directed self-checking bench for rf_wb_arbiter (DEPTH=4, REG_W=5,
//           DATA_W=32). Covers reset, pipeline writes, fill/drain, WAW kill,
//           pointer wrap and simultaneous enqueue/pop.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
    localparam int DEPTH  = 4;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) bus ();

    rf_wb_arbiter #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_wen   = 1'b0;
        bus.pipe_rd    = '0;
        bus.pipe_wdata = '0;
        bus.ll_valid   = 1'b0;
        bus.ll_rd      = '0;
        bus.ll_wdata   = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.rs1 = '0;
        bus.rs2 = '0;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL reset_rf_wen: got %0b want 0", bus.rf_wen); end
        checks++; if (bus.rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rf_rd: got %0d want 0", bus.rf_rd); end
        checks++; if (bus.rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); end
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.ll_ready !== 1'b1) begin failures++; $display("FAIL reset_ll_ready: got %0b want 1", bus.ll_ready); end
        rst = 1'b0;
        tick();
        // Fill 3 entries while the pipeline keeps the port busy.
        bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_wdata = 32'h99;
        for (int i = 1; i <= 3; i++) begin
            bus.ll_valid = 1'b1; bus.ll_rd = REG_W'(i); bus.ll_wdata = 32'h10 * i;
            tick();
            $display("txn enqueue rd=%0d count=%0d", i, bus.fifo_count);
        end
        bus.ll_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd3) begin failures++; $display("FAIL prefill_count: got %0d want 3", bus.fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL async_rst_rf_wen: got %0b want 0", bus.rf_wen); end
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL async_rst_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.ll_ready !== 1'b1) begin failures++; $display("FAIL async_rst_ll_ready: got %0b want 1", bus.ll_ready); end
        idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.rf_wen !== 1'b0 || bus.fifo_count !== 3'd0) begin
                failures++; $display("FAIL post_rst_quiet[%0d]: got wen=%0b count=%0d want wen=0 count=0", i, bus.rf_wen, bus.fifo_count);
            end
        end
    endtask

    task automatic test_pipe_write();
        idle();
        bus.rs1 = 5'd7;
        bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_wdata = 32'hDEADBEEF;
        tick();
        $display("txn pipe rd=7 data=deadbeef");
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL pipe_write: got wen=%0b rd=%0d data=%h want 1/7/deadbeef", bus.rf_wen, bus.rf_rd, bus.rf_wdata);
        end
        checks++; if (bus.rs1_pending !== 1'b1) begin failures++; $display("FAIL pipe_inflight_pending: got %0b want 1", bus.rs1_pending); end
        bus.pipe_rd = 5'd0; bus.pipe_wdata = 32'h1234;
        tick();
        $display("txn pipe rd=0 data=1234");
        checks++; if (bus.rf_wen !== 1'b0 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL pipe_x0: got wen=%0b rd=%0d data=%h want 0/7/deadbeef", bus.rf_wen, bus.rf_rd, bus.rf_wdata);
        end
        checks++; if (bus.rs1_pending !== 1'b0) begin failures++; $display("FAIL pipe_retired_pending: got %0b want 0", bus.rs1_pending); end
        idle();
        bus.rs1 = '0;
    endtask

    task automatic test_fill_drain();
        idle();
        bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_wdata = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.ll_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, bus.ll_ready); end
            bus.ll_valid = 1'b1; bus.ll_rd = REG_W'(i); bus.ll_wdata = 32'h100 + i;
            tick();
            $display("txn enqueue rd=%0d count=%0d", i, bus.fifo_count);
            checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd9) begin
                failures++; $display("FAIL fill_pipe_owns[%0d]: got wen=%0b rd=%0d want 1/9", i, bus.rf_wen, bus.rf_rd);
            end
        end
        checks++; if (bus.fifo_count !== 3'd4 || bus.ll_ready !== 1'b0) begin
            failures++; $display("FAIL full: got count=%0d ready=%0b want 4/0", bus.fifo_count, bus.ll_ready);
        end
        // Offer while full: no transfer.
        bus.ll_rd = 5'd6; bus.ll_wdata = 32'h666;
        tick();
        checks++; if (bus.fifo_count !== 3'd4) begin failures++; $display("FAIL full_no_accept: got %0d want 4", bus.fifo_count); end
        idle();
        for (int i = 1; i <= 4; i++) begin
            tick();
            $display("txn drain rd=%0d data=%h", bus.rf_rd, bus.rf_wdata);
            checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== REG_W'(i) || bus.rf_wdata !== 32'h100 + i) begin
                failures++; $display("FAIL drain[%0d]: got wen=%0b rd=%0d data=%h want 1/%0d/%h", i, bus.rf_wen, bus.rf_rd, bus.rf_wdata, i, 32'h100 + i);
            end
            checks++; if (bus.fifo_count !== 3'(4 - i) || bus.ll_ready !== 1'b1) begin
                failures++; $display("FAIL drain_count[%0d]: got count=%0d ready=%0b want %0d/1", i, bus.fifo_count, bus.ll_ready, 4 - i);
            end
        end
        tick();
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL drain_done: got %0b want 0", bus.rf_wen); end
    endtask

    task automatic test_waw_kill();
        idle();
        bus.rs1 = 5'd5;
        bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_wdata = 32'h99;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd5; bus.ll_wdata = 32'h11;
        tick();
        $display("txn enqueue rd=5 data=11");
        checks++; if (bus.fifo_count !== 3'd1 || bus.rs1_pending !== 1'b1) begin
            failures++; $display("FAIL waw_queued: got count=%0d pend=%0b want 1/1", bus.fifo_count, bus.rs1_pending);
        end
        bus.ll_valid = 1'b0;
        bus.pipe_rd = 5'd5; bus.pipe_wdata = 32'h22;
        tick();
        $display("txn pipe rd=5 data=22");
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'h22 || bus.rs1_pending !== 1'b1) begin
            failures++; $display("FAIL waw_pipe: got wen=%0b rd=%0d data=%h pend=%0b want 1/5/22/1", bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.rs1_pending);
        end
        idle();
        tick();
        checks++; if (bus.rf_wen !== 1'b0 || bus.fifo_count !== 3'd0 || bus.rs1_pending !== 1'b0) begin
            failures++; $display("FAIL waw_killed: got wen=%0b count=%0d pend=%0b want 0/0/0", bus.rf_wen, bus.fifo_count, bus.rs1_pending);
        end
        tick();
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL waw_no_stale: got %0b want 0", bus.rf_wen); end
        // Same-cycle enqueue and pipeline write to the same register.
        bus.rs2 = 5'd6;
        bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd6; bus.pipe_wdata = 32'h66;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd6; bus.ll_wdata = 32'h77;
        tick();
        $display("txn pipe rd=6 data=66 with enqueue rd=6 data=77");
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 32'h66 || bus.fifo_count !== 3'd1 || bus.rs2_pending !== 1'b1) begin
            failures++; $display("FAIL waw_same_cycle: got wen=%0b data=%h count=%0d pend=%0b want 1/66/1/1", bus.rf_wen, bus.rf_wdata, bus.fifo_count, bus.rs2_pending);
        end
        idle();
        tick();
        checks++; if (bus.rf_wen !== 1'b0 || bus.fifo_count !== 3'd0 || bus.rs2_pending !== 1'b0) begin
            failures++; $display("FAIL waw_same_cycle_kill: got wen=%0b count=%0d pend=%0b want 0/0/0", bus.rf_wen, bus.fifo_count, bus.rs2_pending);
        end
        bus.rs1 = '0;
        bus.rs2 = '0;
    endtask

    task automatic test_wrap();
        idle();
        for (int k = 0; k < 10; k++) begin
            bus.ll_valid = 1'b1; bus.ll_rd = REG_W'(k + 1); bus.ll_wdata = 32'hA000 + k;
            tick();
            bus.ll_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
            checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== REG_W'(k + 1) || bus.rf_wdata !== 32'hA000 + k || bus.fifo_count !== 3'd0) begin
                failures++; $display("FAIL wrap_bypass[%0d]: got wen=%0b rd=%0d data=%h count=%0d want 1/%0d/%h/0", k, bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.fifo_count, k + 1, 32'hA000 + k);
            end
            tick();
            checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL wrap_bypass_idle[%0d]: got %0b want 0", k, bus.rf_wen); end
`else
            checks++; if (bus.rf_wen !== 1'b0 || bus.fifo_count !== 3'd1) begin
                failures++; $display("FAIL wrap_enq[%0d]: got wen=%0b count=%0d want 0/1", k, bus.rf_wen, bus.fifo_count);
            end
            tick();
            checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== REG_W'(k + 1) || bus.rf_wdata !== 32'hA000 + k || bus.fifo_count !== 3'd0) begin
                failures++; $display("FAIL wrap_out[%0d]: got wen=%0b rd=%0d data=%h count=%0d want 1/%0d/%h/0", k, bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.fifo_count, k + 1, 32'hA000 + k);
            end
`endif
            $display("txn wrap rd=%0d data=%h", k + 1, 32'hA000 + k);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_wdata = 32'h99;
        // x0 result: handshake completes, nothing stored.
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd0; bus.ll_wdata = 32'hBAD;
        tick();
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL x0_not_stored: got %0d want 0", bus.fifo_count); end
        bus.ll_rd = 5'd11; bus.ll_wdata = 32'hB1;
        tick();
        bus.ll_rd = 5'd12; bus.ll_wdata = 32'hB2;
        tick();
        checks++; if (bus.fifo_count !== 3'd2) begin failures++; $display("FAIL b2b_prefill: got %0d want 2", bus.fifo_count); end
        bus.pipe_wen = 1'b0;
        bus.ll_rd = 5'd13; bus.ll_wdata = 32'hB3;
        tick();
        $display("txn enq rd=13 pop rd=%0d", bus.rf_rd);
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd11 || bus.rf_wdata !== 32'hB1 || bus.fifo_count !== 3'd2) begin
            failures++; $display("FAIL b2b_first: got wen=%0b rd=%0d data=%h count=%0d want 1/11/b1/2", bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.fifo_count);
        end
        bus.ll_rd = 5'd14; bus.ll_wdata = 32'hB4;
        tick();
        $display("txn enq rd=14 pop rd=%0d", bus.rf_rd);
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd12 || bus.rf_wdata !== 32'hB2 || bus.fifo_count !== 3'd2) begin
            failures++; $display("FAIL b2b_second: got wen=%0b rd=%0d data=%h count=%0d want 1/12/b2/2", bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.fifo_count);
        end
        bus.ll_valid = 1'b0;
        tick();
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd13 || bus.rf_wdata !== 32'hB3 || bus.fifo_count !== 3'd1) begin
            failures++; $display("FAIL b2b_third: got wen=%0b rd=%0d data=%h count=%0d want 1/13/b3/1", bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.fifo_count);
        end
        tick();
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd14 || bus.rf_wdata !== 32'hB4 || bus.fifo_count !== 3'd0) begin
            failures++; $display("FAIL b2b_fourth: got wen=%0b rd=%0d data=%h count=%0d want 1/14/b4/0", bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.fifo_count);
        end
        tick();
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL b2b_done: got %0b want 0", bus.rf_wen); end
    endtask

    initial begin
        idle();
        bus.rs1 = '0;
        bus.rs2 = '0;
        test_reset();
        test_pipe_write();
        test_fill_drain();
        test_waw_kill();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-side front end of the register file: merges two write sources into the single register-file write port.
  - In-order pipeline writeback.
  - Long-latency unit results, e.g. mul/div, arriving over a valid/ready handshake.
- Long-latency results are queued in a small FIFO and drained when the pipeline does not use the port.
- Younger pipeline writes kill stale queued writes to the same register (WAW).
- Pending-write status is exported for the hazard unit.

Parameters:
- DEPTH, 4, long-latency FIFO entries, power of two, 2..16.
- REG_W, 5, register index width; 4 for RV32E builds.
- DATA_W, 32, write data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- pipe_wen  in  1  pipeline writeback valid this cycle.
- pipe_rd  in  REG_W  pipeline destination register.
- pipe_wdata  in  DATA_W  pipeline write data.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  arbiter accepts long-latency result.
- ll_rd  in  REG_W  long-latency destination.
- ll_wdata  in  DATA_W  long-latency data.
- rs1  in  REG_W  hazard query index 1.
- rs2  in  REG_W  hazard query index 2.
- rs1_pending  out  1  a queued or in-flight write targets rs1.
- rs2_pending  out  1  a queued or in-flight write targets rs2.
- rf_wen  out  1  register-file write enable (registered).
- rf_rd  out  REG_W  register-file write index (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- fifo_count  out  clog2(DEPTH)+1  occupied entries, including killed ones.

Behaviour:
- Reset:
  - FIFO empty; all entry valid bits 0.
  - rf_wen = 0, rf_rd = 0, rf_wdata = 0, fifo_count = 0.
  - ll_ready = 1 after reset.
  - An asserted RST mid-operation discards all queued entries; nothing is written.
- FIFO organisation: circular buffer with head/tail pointers and count. Each entry holds {live, rd, wdata}.
- Enqueue (handshake):
  - ll_ready = (count < DEPTH). ll_ready depends only on registered count, not on a same-cycle dequeue.
  - Transfer occurs when ll_valid && ll_ready.
  - ll_rd == 0: transfer is accepted but not stored.
- Output register selection, evaluated each cycle; the result loads on the next edge:
  - Priority 1: pipe_wen && pipe_rd != 0. Load the pipeline write. The FIFO does not drain.
  - Priority 2: otherwise, if the head entry is live, load the head and pop it.
  - Otherwise: rf_wen <= 0, and rf_rd/rf_wdata hold their previous values.
- Killed head: if the head entry is not live, it is popped regardless of pipeline activity, with no write. At most one pop per cycle.
- WAW kill: when pipe_wen && pipe_rd != 0, every live entry with rd == pipe_rd is cleared to not-live in the same cycle.
  - An entry enqueued in that same cycle with the same rd is also stored not-live. The pipeline write is treated as younger.
- Simultaneous enqueue and pop: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency:
  - Pipeline write to rf_wen: 1 cycle.
  - Long-latency result into an empty FIFO with an idle pipeline: 2 cycles (enqueue, then drain).
- Pending query (combinational from registered state):
  - rsN_pending = (rsN != 0) && (any live entry with rd == rsN || (rf_wen && rf_rd == rsN)).
- Indices above the RV32E range are passed through unchanged; legality is checked by decode.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: when the FIFO count is 0, the pipeline slot is free (no pipe_wen, or pipe_rd == 0), and ll_valid is high:
  - The long-latency result loads directly into the output register.
  - It is not enqueued; ll_ready stays 1.
  - Latency drops to 1 cycle.
- Undefined: all long-latency results pass through the FIFO (2-cycle minimum latency).

Test Plan:
- Reset with RST high mid-stream while the FIFO holds 3 entries -> rf_wen = 0, fifo_count = 0, ll_ready = 1 the same cycle; no writes after release.
- pipe_wen = 1, pipe_rd = 7, pipe_wdata = 0xDEADBEEF -> next cycle rf_wen = 1, rf_rd = 7, rf_wdata = 0xDEADBEEF. Repeat with pipe_rd = 0 -> rf_wen = 0.
- Fill 4 long-latency results (rd = 1..4) while pipe_wen is held high on rd = 9 -> ll_ready = 0 at count 4. Drop pipe_wen -> writes rd 1, 2, 3, 4 on consecutive cycles; ll_ready returns to 1 after the first pop.
- Enqueue ll rd = 5 (0x11), then pipe write rd = 5 (0x22) before the drain -> only the 0x22 write to rd 5 occurs. rs1 = 5 shows pending = 1 until the kill cycle, then 0 once rf_wen for 0x22 retires.
- Wrap-around: 10 single long-latency transfers with an idle pipeline -> each appears in order, 2 cycles after its handshake (1 cycle with RF_WB_BYPASS_EN); pointers wrap without loss.
- Simultaneous enqueue and pop at count = 2 -> count stays 2; data order is preserved.
